// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_ctrl
//  Description : Scan controller for a 4-digit multiplexed 7-segment display.
//                Time-slices the digits into fixed slots, blanks the start of
//                every slot to suppress ghosting, applies per-digit enable and
//                global PWM brightness, and latches the digit data once per
//                frame so that a frame never shows a torn value.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1  system clock, all logic on posedge
//    rst         in   1  asynchronous, active-low reset
//    en          in   1  scan enable; low = display dark, scan held at digit 0
//    digit_en    in   4  per-digit enable, bit i = digit i
//    bright      in   4  PWM duty: 0 = off, 15 = full on
//    LED0..LED3  in   7  segment patterns for digits 0..3
//    LEDOUT      out  7  segment drive, registered
//    LEDSEL      out  4  anode select, active-low, one-hot-zero, registered
//    cur_digit   out  2  index of the digit whose slot is in progress
//    frame_done  out  1  one-cycle pulse at the end of the digit-3 slot
// ============================================================================
module led_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
  input  logic [3:0] bright,
  input  logic [6:0] LED0,
  input  logic [6:0] LED1,
  input  logic [6:0] LED2,
  input  logic [6:0] LED3,
  output logic [6:0] LEDOUT,
  output logic [3:0] LEDSEL,
  output logic [1:0] cur_digit,
  output logic       frame_done
);

  localparam int                 c_CNT_W     = $clog2(TICK_DIV);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(BLANK_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  // Only the low nibble of on_cnt matters for PWM, and the low nibble of a
  // difference depends only on the low nibbles of its operands.
  localparam logic [3:0]         c_BLANK_LO  = 4'(BLANK_CYC % 16);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_slot_cnt;
  logic [1:0]         r_idx;
  logic [6:0]         r_shadow [4];

  logic [3:0]         w_on_lo;
  logic               w_pwm_ok;
  logic               w_lit;
  logic               w_wrap;

  assign w_on_lo   = r_slot_cnt[3:0] - c_BLANK_LO;
  assign w_pwm_ok  = (bright == 4'hF) || (w_on_lo < bright);
  assign w_lit     = (r_state == S_ON) && digit_en[r_idx] && w_pwm_ok;
  assign w_wrap    = (r_slot_cnt == c_LAST);
  assign cur_digit = r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_slot_cnt <= '0;
      r_idx      <= 2'd0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      LEDSEL     <= 4'b1111;
      LEDOUT     <= '0;
      frame_done <= 1'b0;
    end else begin
      // Outputs reflect the state/counter values held before this edge.
      LEDSEL     <= w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
      LEDOUT     <= w_lit ? r_shadow[r_idx] : 7'd0;
      frame_done <= 1'b0;

      if (!en) begin
        r_state    <= S_IDLE;
        r_slot_cnt <= '0;
        r_idx      <= 2'd0;
      end else begin
        case (r_state)
          S_BLANK, S_ON: begin
            if (w_wrap) begin
              r_slot_cnt <= '0;
              r_idx      <= r_idx + 2'd1;
              r_state    <= S_BLANK;
              // Frame boundary: the only place the shadows change mid-scan.
              if (r_idx == 2'd3) begin
                r_shadow[0] <= LED0;
                r_shadow[1] <= LED1;
                r_shadow[2] <= LED2;
                r_shadow[3] <= LED3;
                frame_done  <= 1'b1;
              end
            end else begin
              r_slot_cnt <= r_slot_cnt + c_CNT_ONE;
              if (r_slot_cnt == c_BLANK_END) r_state <= S_ON;
            end
          end
          default: begin
            // Leaving IDLE: digit 0 starts at slot_cnt 0 with fresh data.
            r_state     <= S_BLANK;
            r_slot_cnt  <= '0;
            r_idx       <= 2'd0;
            r_shadow[0] <= LED0;
            r_shadow[1] <= LED1;
            r_shadow[2] <= LED2;
            r_shadow[3] <= LED3;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_scan_ctrl
//  Description : Self-checking bench for led_scan_ctrl (TICK_DIV=40,
//                BLANK_CYC=8). Table of directed vectors plus hand-written
//                sequences for reset, PWM, masking, tearing and en drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scan_ctrl;

  localparam int TICK_DIV  = 40;
  localparam int BLANK_CYC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digit_en;
  logic [3:0] bright;
  logic [6:0] LED0, LED1, LED2, LED3;
  logic [6:0] LEDOUT;
  logic [3:0] LEDSEL;
  logic [1:0] cur_digit;
  logic       frame_done;

  led_scan_ctrl #(.TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_en   (digit_en),
    .bright     (bright),
    .LED0       (LED0),
    .LED1       (LED1),
    .LED2       (LED2),
    .LED3       (LED3),
    .LEDOUT     (LEDOUT),
    .LEDSEL     (LEDSEL),
    .cur_digit  (cur_digit),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  // tcur = number of posedges since the enabling edge E0, observed at the
  // negedge after edge E_tcur.
  int tcur    = 0;

  typedef struct {
    logic [3:0] de;
    logic [3:0] br;
    int         t;
    logic [3:0] sel;
    logic [6:0] out;
    logic       fd;
    logic [1:0] cur;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, tcur);
    end
  endtask

  task automatic start_scan();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tcur = 0;
  endtask

  task automatic advance_to(input int t);
    while (tcur < t) begin
      @(posedge clk);
      @(negedge clk);
      tcur++;
    end
  endtask

  function automatic vec_t mk(input logic [3:0] de, input logic [3:0] br, input int t,
                              input logic [3:0] sel, input logic [6:0] out,
                              input logic fd, input logic [1:0] cur);
    vec_t v;
    v.de = de; v.br = br; v.t = t; v.sel = sel; v.out = out; v.fd = fd; v.cur = cur;
    return v;
  endfunction

  initial begin
    int lit_cnt;
    int fd_cnt;
    bit first;

    rst = 1'b0; en = 1'b0; digit_en = 4'hF; bright = 4'hF;
    LED0 = 7'h01; LED1 = 7'h02; LED2 = 7'h04; LED3 = 7'h08;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_sel", 32'(LEDSEL), 32'hF);
    check("rst_out", 32'(LEDOUT), 32'h0);
    check("rst_cur", 32'(cur_digit), 32'h0);
    check("rst_fd",  32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- vector table ----------------
    // t -> observed registers after edge E_t: slot=(t-1)/40, pos=(t-1)%40.
    vecs.push_back(mk(4'hF, 4'hF,   1, 4'b1111, 7'h00, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'hF,   8, 4'b1111, 7'h00, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'hF,   9, 4'b1110, 7'h01, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'hF,  40, 4'b1110, 7'h01, 1'b0, 2'd1));
    vecs.push_back(mk(4'hF, 4'hF,  41, 4'b1111, 7'h00, 1'b0, 2'd1));
    vecs.push_back(mk(4'hF, 4'hF,  49, 4'b1101, 7'h02, 1'b0, 2'd1));
    vecs.push_back(mk(4'hF, 4'hF,  89, 4'b1011, 7'h04, 1'b0, 2'd2));
    vecs.push_back(mk(4'hF, 4'hF, 129, 4'b0111, 7'h08, 1'b0, 2'd3));
    vecs.push_back(mk(4'hF, 4'hF, 159, 4'b0111, 7'h08, 1'b0, 2'd3));
    vecs.push_back(mk(4'hF, 4'hF, 160, 4'b0111, 7'h08, 1'b1, 2'd0));
    vecs.push_back(mk(4'hF, 4'hF, 161, 4'b1111, 7'h00, 1'b0, 2'd0));
    // PWM bright=4: lit while on_cnt[3:0] in 0..3
    vecs.push_back(mk(4'hF, 4'h4,   9, 4'b1110, 7'h01, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'h4,  12, 4'b1110, 7'h01, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'h4,  13, 4'b1111, 7'h00, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'h4,  24, 4'b1111, 7'h00, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'h4,  25, 4'b1110, 7'h01, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'h4,  29, 4'b1111, 7'h00, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'h0,   9, 4'b1111, 7'h00, 1'b0, 2'd0));
    // Mask digit_en=0101
    vecs.push_back(mk(4'h5, 4'hF,   9, 4'b1110, 7'h01, 1'b0, 2'd0));
    vecs.push_back(mk(4'h5, 4'hF,  49, 4'b1111, 7'h00, 1'b0, 2'd1));
    vecs.push_back(mk(4'h5, 4'hF,  89, 4'b1011, 7'h04, 1'b0, 2'd2));
    vecs.push_back(mk(4'h5, 4'hF, 129, 4'b1111, 7'h00, 1'b0, 2'd3));

    first = 1'b1;
    foreach (vecs[i]) begin
      if (first || vecs[i].de != digit_en || vecs[i].br != bright || vecs[i].t <= tcur) begin
        @(negedge clk);
        digit_en = vecs[i].de;
        bright   = vecs[i].br;
        start_scan();
        first = 1'b0;
      end
      advance_to(vecs[i].t);
      check($sformatf("vec%0d_sel", i), 32'(LEDSEL),     32'(vecs[i].sel));
      check($sformatf("vec%0d_out", i), 32'(LEDOUT),     32'(vecs[i].out));
      check($sformatf("vec%0d_fd",  i), 32'(frame_done), 32'(vecs[i].fd));
      check($sformatf("vec%0d_cur", i), 32'(cur_digit),  32'(vecs[i].cur));
    end

    // ---------------- PWM lit count over digit 0's slot ----------------
    @(negedge clk);
    digit_en = 4'hF; bright = 4'h4;
    start_scan();
    lit_cnt = 0;
    while (tcur < 40) begin
      advance_to(tcur + 1);
      if (LEDSEL != 4'b1111) lit_cnt++;
    end
    check("pwm_lit_count", 32'(lit_cnt), 32'd8);

    // ---------------- frame_done count over two frames ----------------
    @(negedge clk);
    bright = 4'hF;
    start_scan();
    fd_cnt = 0;
    while (tcur < 320) begin
      advance_to(tcur + 1);
      if (frame_done) fd_cnt++;
    end
    check("fd_count", 32'(fd_cnt), 32'd2);

    // ---------------- no tearing ----------------
    start_scan();
    advance_to(50);
    LED2 = 7'h7F;
    advance_to(89);
    check("tear_same_frame", 32'(LEDOUT), 32'h04);
    advance_to(249);
    check("tear_next_frame", 32'(LEDOUT), 32'h7F);
    check("tear_next_sel",   32'(LEDSEL), 32'b1011);
    LED2 = 7'h04;

    // ---------------- async reset mid-ON on digit 2 ----------------
    start_scan();
    advance_to(100);
    check("pre_rst_sel", 32'(LEDSEL), 32'b1011);
    #2 rst = 1'b0;
    #1;
    check("async_rst_sel", 32'(LEDSEL), 32'hF);
    check("async_rst_out", 32'(LEDOUT), 32'h0);
    check("async_rst_cur", 32'(cur_digit), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tcur = 0;
    advance_to(8);
    check("post_rst_blank", 32'(LEDSEL), 32'hF);
    advance_to(9);
    check("post_rst_sel", 32'(LEDSEL), 32'b1110);
    check("post_rst_out", 32'(LEDOUT), 32'h01);

    // ---------------- en drop mid-slot on digit 1 ----------------
    start_scan();
    advance_to(60);
    check("pre_drop_sel", 32'(LEDSEL), 32'b1101);
    en = 1'b0;
    fd_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    check("drop_sel", 32'(LEDSEL), 32'hF);
    check("drop_out", 32'(LEDOUT), 32'h0);
    check("drop_cur", 32'(cur_digit), 32'h0);
    repeat (50) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    check("drop_no_fd", 32'(fd_cnt), 32'd0);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tcur = 0;
    advance_to(8);
    check("reen_blank", 32'(LEDSEL), 32'hF);
    advance_to(9);
    check("reen_sel", 32'(LEDSEL), 32'b1110);
    advance_to(40);
    check("reen_end_sel", 32'(LEDSEL), 32'b1110);
    advance_to(41);
    check("reen_next_blank", 32'(LEDSEL), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
